// File: rtl/i2s_rx_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_capture_if
// Brief    : Sample-RAM write port driven by the I2S capture block.
// Revision : 1.0
// ============================================================================
interface i2s_rx_capture_if #(
   parameter int DATA_WIDTH = 16,
   parameter int RAM_WIDTH  = 14
);
   logic                  wr_en;
   logic [RAM_WIDTH-1:0]  wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/i2s_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_capture
// Brief    : Oversampling I2S receiver filling the sample RAM once per start.
//            Define I2S_RX_STEREO_EN to store right words as well (interleaved).
// Revision : 1.0
// ============================================================================
module i2s_rx_capture #(
   parameter int DATA_WIDTH = 16,
   parameter int RAM_WIDTH  = 14
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          i2s_sck,
   input  wire logic          i2s_ws,
   input  wire logic          i2s_sd,
   input  wire logic          start,
   output logic               busy,
   output logic               done,
   i2s_rx_capture_if.master   ram_wr
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0]         c_cnt_sat  = CW'(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] c_msb_mask = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SYNC    = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            sck_sync_q;
   logic [1:0]            ws_sync_q;
   logic [1:0]            sd_sync_q;
   logic                  ws_prev_q, ws_prev_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]         bitcnt_q, bitcnt_d;
   logic                  wr_en_q, wr_en_d;
   logic [RAM_WIDTH-1:0]  wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   logic                  w_sck_rise;
   logic                  w_ws;
   logic                  w_sd;
   logic                  w_word_end;
   logic                  w_store;
   logic [DATA_WIDTH-1:0] w_mask;
   logic [DATA_WIDTH-1:0] w_shift_in;

   // sck_sync_q[2] is the delayed copy of the second synchronizer stage
   assign w_sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
   assign w_ws       = ws_sync_q[1];
   assign w_sd       = sd_sync_q[1];
   assign w_word_end = w_sck_rise && (w_ws != ws_prev_q);

   // Mask shifts out entirely once the counter saturates, dropping excess bits
   assign w_mask     = c_msb_mask >> bitcnt_q;
   assign w_shift_in = w_sd ? (shift_q | w_mask) : (shift_q & ~w_mask);

`ifdef I2S_RX_STEREO_EN
   assign w_store = 1'b1;
`else
   assign w_store = ~ws_prev_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync_q <= '0;
         ws_sync_q  <= '0;
         sd_sync_q  <= '0;
         ws_prev_q  <= 1'b0;
         shift_q    <= '0;
         bitcnt_q   <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         state_q    <= S_IDLE;
      end else begin
         sck_sync_q <= {sck_sync_q[1:0], i2s_sck};
         ws_sync_q  <= {ws_sync_q[0], i2s_ws};
         sd_sync_q  <= {sd_sync_q[0], i2s_sd};
         ws_prev_q  <= ws_prev_d;
         shift_q    <= shift_d;
         bitcnt_q   <= bitcnt_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         state_q    <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ws_prev_d = ws_prev_q;
      shift_d   = shift_q;
      bitcnt_d  = bitcnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      if (w_sck_rise) begin
         ws_prev_d = w_ws;
         if (w_word_end) begin
            shift_d  = '0;
            bitcnt_d = '0;
         end else begin
            shift_d = w_shift_in;
            if (bitcnt_q != c_cnt_sat) begin
               bitcnt_d = bitcnt_q + 1'b1;
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SYNC;
               wr_addr_d = '0;
            end
         end
         S_SYNC: begin
            if (w_word_end && ws_prev_q) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            // Address advances on the edge that closes the write strobe
            if (wr_en_q) begin
               wr_addr_d = wr_addr_q + 1'b1;
               if (&wr_addr_q) begin
                  state_d = S_DONE;
               end
            end else if (w_word_end && w_store) begin
               wr_en_d   = 1'b1;
               wr_data_d = w_shift_in;
            end
         end
         S_DONE: begin
            if (start) begin
               state_d   = S_SYNC;
               wr_addr_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy           = (state_q == S_SYNC) || (state_q == S_CAPTURE);
   assign done           = (state_q == S_DONE);
   assign ram_wr.wr_en   = wr_en_q;
   assign ram_wr.wr_addr = wr_addr_q;
   assign ram_wr.wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx_capture
// Brief    : Self-checking bench; word-level reference model of the capture.
// Revision : 1.0
// ============================================================================
module tb_i2s_rx_capture;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
`ifdef I2S_RX_STEREO_EN
   localparam bit STEREO = 1'b1;
`else
   localparam bit STEREO = 1'b0;
`endif
   localparam int M_IDLE = 0, M_SYNC = 1, M_CAP = 2, M_DONE = 3;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic i2s_sck = 1'b0, i2s_ws = 1'b0, i2s_sd = 1'b0;
   logic busy, done;

   int n_checks = 0;
   int n_fail   = 0;
   logic [AW+DW-1:0] got_q[$];
   logic [AW+DW-1:0] exp_q[$];
   int m_state = M_IDLE;
   int m_addr  = 0;

   i2s_rx_capture_if #(.DATA_WIDTH(DW), .RAM_WIDTH(AW)) wr_if ();

   i2s_rx_capture #(.DATA_WIDTH(DW), .RAM_WIDTH(AW)) dut (
      .clk     (clk),
      .rst     (rst),
      .i2s_sck (i2s_sck),
      .i2s_ws  (i2s_ws),
      .i2s_sd  (i2s_sd),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .ram_wr  (wr_if)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_if.wr_en === 1'b1) got_q.push_back({wr_if.wr_addr, wr_if.wr_data});
   end

   // Left-justified, truncated sample value of an nbits-wide word
   function automatic logic [DW-1:0] expect_word(input logic [31:0] val, input int nbits);
      if (nbits >= DW) return DW'(val >> (nbits - DW));
      else             return DW'(val << (DW - nbits));
   endfunction

   task automatic model_start();
      if (m_state == M_IDLE || m_state == M_DONE) begin
         m_state = M_SYNC;
         m_addr  = 0;
      end
   endtask

   task automatic model_word(input logic ch, input logic [31:0] val, input int nbits);
      if (m_state == M_SYNC) begin
         if (ch) m_state = M_CAP;
      end else if (m_state == M_CAP) begin
         if (STEREO || !ch) begin
            exp_q.push_back({AW'(m_addr), expect_word(val, nbits)});
            m_addr++;
            if (m_addr == DEPTH) begin
               m_addr  = 0;
               m_state = M_DONE;
            end
         end
      end
   endtask

   task automatic drive_bit(input logic ws, input logic sd);
      i2s_sck = 1'b0;
      i2s_ws  = ws;
      i2s_sd  = sd;
      repeat (4) @(negedge clk);
      i2s_sck = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      model_start();
   endtask

   // ch: 0 = left, 1 = right; the LSB rides on the first edge of the other channel
   task automatic send_word(input logic ch, input logic [31:0] val, input int nbits, input int start_at);
      for (int i = 0; i < nbits; i++) begin
         if (i == start_at) pulse_start();
         drive_bit((i == nbits - 1) ? ~ch : ch, val[nbits-1-i]);
      end
      model_word(ch, val, nbits);
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
      send_word(1'b0, l, 16, -1);
      send_word(1'b1, r, 16, -1);
   endtask

   task automatic do_reset();
      i2s_sck = 1'b0;
      start   = 1'b0;
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      got_q.delete();
      exp_q.delete();
      m_state = M_IDLE;
      m_addr  = 0;
   endtask

   task automatic test_reset();
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i2s_sck = 1'($urandom); i2s_ws = 1'($urandom); i2s_sd = 1'($urandom);
         @(negedge clk);
      end
      n_checks++; if (wr_if.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_if.wr_en); end
      n_checks++; if (wr_if.wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", wr_if.wr_addr); end
      n_checks++; if (wr_if.wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_if.wr_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      rst = 1'b0;
      got_q.delete();
      for (int i = 0; i < 40; i++) drive_bit(1'($urandom), 1'($urandom));
      repeat (8) @(negedge clk);
      n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_no_write: got %0d writes want 0", got_q.size()); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_mono_frame();
      do_reset();
      i2s_ws = 1'b1;
      pulse_start();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy: got %b want 1", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL frame_done: got %b want 0", done); end
      send_word(1'b1, $urandom, 16, -1);
      repeat (3) send_frame(32'hA5C3, 32'h1234);
      repeat (8) @(negedge clk);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL frame_count: got %0d writes want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL frame_write[%0d]: got addr/data %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_width();
      int idx;
      do_reset();
      i2s_ws = 1'b1;
      pulse_start();
      send_word(1'b1, $urandom, 16, -1);
      send_word(1'b0, 32'hABC, 12, -1);
      send_word(1'b1, $urandom, 16, -1);
      send_word(1'b0, 32'h123456, 24, -1);
      send_word(1'b1, $urandom, 16, -1);
      repeat (8) @(negedge clk);
      idx = STEREO ? 2 : 1;
      n_checks++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL width_count: got %0d writes want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL width_write[%0d]: got addr/data %h want %h", i, got_q[i], exp_q[i]); end
      end
      if (got_q.size() > idx) begin
         n_checks++;
         if (got_q[0][DW-1:0] !== 16'hABC0) begin n_fail++; $display("FAIL width_short: got %h want abc0", got_q[0][DW-1:0]); end
         n_checks++;
         if (got_q[idx][DW-1:0] !== 16'h1234) begin n_fail++; $display("FAIL width_long: got %h want 1234", got_q[idx][DW-1:0]); end
      end else begin
         n_checks++; n_fail++;
         $display("FAIL width_missing: got %0d writes want > %0d", got_q.size(), idx);
      end
   endtask

   task automatic test_random();
      do_reset();
      i2s_ws = 1'b1;
      pulse_start();
      send_word(1'b1, $urandom, $urandom_range(8, 24), -1);
      for (int f = 0; f < 6; f++) begin
         send_word(1'b0, $urandom, $urandom_range(8, 24), -1);
         send_word(1'b1, $urandom, $urandom_range(8, 24), -1);
      end
      repeat (8) @(negedge clk);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d writes want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_write[%0d]: got addr/data %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_align();
      do_reset();
      send_frame($urandom, $urandom);
      send_word(1'b1, $urandom, 16, 6);
      send_frame($urandom, $urandom);
      send_frame($urandom, $urandom);
      repeat (8) @(negedge clk);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL align_count: got %0d writes want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL align_write[%0d]: got addr/data %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_fill();
      int guard;
      do_reset();
      i2s_ws = 1'b1;
      pulse_start();
      send_word(1'b1, $urandom, 16, -1);
      guard = 0;
      while (m_state != M_DONE && guard < 40) begin
         send_frame($urandom, $urandom);
         guard++;
      end
      send_frame($urandom, $urandom);
      repeat (8) @(negedge clk);
      n_checks++;
      if (got_q.size() != DEPTH) begin n_fail++; $display("FAIL fill_count: got %0d writes want %0d", got_q.size(), DEPTH); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fill_write[%0d]: got addr/data %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL fill_done: got %b want 1", done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_busy: got %b want 0", busy); end
      got_q.delete();
      exp_q.delete();
      pulse_start();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rearm_busy: got %b want 1", busy); end
      send_word(1'b1, $urandom, 16, -1);
      send_frame($urandom, $urandom);
      repeat (8) @(negedge clk);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rearm_count: got %0d writes want %0d", got_q.size(), exp_q.size()); end
      if (got_q.size() > 0) begin
         n_checks++;
         if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rearm_first: got addr/data %h want %h", got_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_midreset();
      logic [15:0] w;
      do_reset();
      i2s_ws = 1'b1;
      pulse_start();
      send_word(1'b1, $urandom, 16, -1);
      send_frame(32'hA5C3, $urandom);
      w = 16'h5A5A;
      for (int i = 0; i < 8; i++) drive_bit(1'b0, w[15-i]);
      @(negedge clk) rst = 1'b1;
      m_state = M_IDLE;
      @(negedge clk);
      n_checks++; if (wr_if.wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en: got %b want 0", wr_if.wr_en); end
      n_checks++; if (wr_if.wr_addr !== '0) begin n_fail++; $display("FAIL midrst_wr_addr: got %h want 0", wr_if.wr_addr); end
      n_checks++; if (wr_if.wr_data !== '0) begin n_fail++; $display("FAIL midrst_wr_data: got %h want 0", wr_if.wr_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
      rst = 1'b0;
      for (int i = 8; i < 16; i++) drive_bit((i == 15) ? 1'b1 : 1'b0, w[15-i]);
      send_word(1'b1, $urandom, 16, -1);
      repeat (8) @(negedge clk);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_count: got %0d writes want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_write[%0d]: got addr/data %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_mono_frame();
      test_width();
      test_random();
      test_align();
      test_fill();
      test_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2s_rx_capture.md
# i2s_rx_capture

I2S receiver that deserializes a serial audio stream into DATA_WIDTH-bit samples and writes them through the write port of the sample dual-port RAM. It is the producer of the sample RAM: it drives the RAM write-enable, write-address and write-data inputs. It runs in the system clock domain and oversamples the external I2S SCK, WS and SD lines. A capture is armed by a single start pulse and fills the RAM once, from address 0 to the last address.

## Interface
- DATA_WIDTH, 16, sample width in bits; equals the RAM word width.
- RAM_WIDTH, 14, RAM address width; a capture writes 2^RAM_WIDTH words.

- clk  input  1  system clock; frequency ≥ 4× i2s_sck.
- rst  input  1  reset; synchronous, active-high.
- i2s_sck  input  1  I2S bit clock; asynchronous to clk.
- i2s_ws  input  1  word select; 0 = left, 1 = right; asynchronous.
- i2s_sd  input  1  serial data, MSB first; asynchronous.
- start  input  1  one-clk pulse; arms a capture.
- wr_en  output  1  one-clk write strobe to the RAM.
- wr_addr  output  RAM_WIDTH  RAM write address.
- wr_data  output  DATA_WIDTH  RAM write data.
- busy  output  1  high in SYNC and CAPTURE.
- done  output  1  high in DONE; means the RAM is full.

## Operation
- i2s_sck, i2s_ws and i2s_sd each pass through a 2-FF synchronizer.
- A rising SCK edge is detected when the synchronized SCK is 1 and its delayed copy is 0. All protocol actions occur only on detected rising edges.
- At each detected edge, the synchronized SD and WS are sampled. ws_prev is the WS value sampled at the previous edge.
- Word framing follows standard I2S:
  - The bit sampled on the edge where WS != ws_prev is the LSB slot of the previous word and belongs to that word.
  - The word is completed after that bit is taken.
  - The following edge carries the MSB of the new word.
- Word assembly:
  - The shift register is cleared at each word start.
  - Bit n of the word (n = 0 for the MSB) is written to position DATA_WIDTH-1-n.
  - Bits with n ≥ DATA_WIDTH are dropped (truncation).
  - Missing LSBs stay 0 (left-justified zero-fill).
- FSM states:
  - IDLE: start → SYNC. wr_addr is cleared to 0.
  - SYNC: wait for a WS 1→0 transition. The partial word in progress is discarded. Then → CAPTURE; the next edge begins the left word.
  - CAPTURE: on each word completion, if that channel is stored, pulse wr_en with wr_data and the current wr_addr. wr_addr increments after the write. A write at address 2^RAM_WIDTH-1 → DONE, and wr_addr wraps to 0.
  - DONE: no writes. start → SYNC with wr_addr = 0.
- start is ignored in SYNC and CAPTURE.
- Channel storage: mono mode stores only left words (words completed on a WS 0→1 transition).
- Reset values: wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0, done = 0, state IDLE.
- A synchronous rst mid-word or mid-capture drops any partial word with no wr_en. The block returns to IDLE on that edge.
- rst and start asserted in the same cycle: rst wins.

## Timing
- Synchronizer: i2s_sck is first seen high in sync stage 1 at clk edge k, and the edge is detected combinationally after edge k+1.
- The resulting action (shift, or wr_en assertion) is registered at edge k+2.
- wr_en is high for exactly one clk cycle. wr_addr and wr_data are stable during that cycle. wr_data holds its value until the next write.
- wr_addr increments on the clk edge that ends the wr_en cycle.
- done rises on the same edge as the increment after the final write. busy falls on that same edge.
- Capture has no backpressure: the RAM accepts one write per clk.
- At most one write occurs per half WS frame. This is far below the write capacity at clk ≥ 4× SCK.

## Configuration
- I2S_RX_STEREO_EN:
  - Defined: both left and right words are stored, interleaved. Left goes to even addresses, right to odd addresses, with the left word first after SYNC. A capture therefore holds 2^(RAM_WIDTH-1) stereo frames.
  - Undefined: only left words are stored, at consecutive addresses; right words are assembled and discarded.

## Test plan
- Reset: hold rst for 3 clk with random I2S activity → wr_en, wr_addr, wr_data, busy and done all 0; no wr_en until start.
- Mono frame: start, then frames left=16'hA5C3, right=16'h1234 at clk = 8× SCK:
  - busy = 1 after start.
  - Exactly one wr_en per frame, at wr_addr 0, 1, … with wr_data 16'hA5C3.
  - 16'h1234 is never written.
- Stereo (I2S_RX_STEREO_EN): same stimulus → writes at addr 0 = 16'hA5C3, addr 1 = 16'h1234, addr 2 = 16'hA5C3.
- Width mismatch:
  - 12-bit left word 12'hABC → wr_data 16'hABC0.
  - 24-bit left word 24'h123456 → wr_data 16'h1234.
- Fill and re-arm (RAM_WIDTH=4, mono):
  - 16 writes at addr 0..15, then done = 1, busy = 0, no further wr_en.
  - start → next write at addr 0.
- Mid-capture reset and start alignment:
  - start pulsed while WS = 1 → the partial right word and the first transition are ignored; the first write is the next full left word.
  - rst asserted mid-word → no wr_en for that word; all outputs 0 the next cycle.
